// File: rtl/ov7670_pkg.sv
// Shared types and widths for the OV7670 capture path and the frame buffer write port.
package ov7670_pkg;

  localparam int unsigned X_W             = 10;
  localparam int unsigned Y_W             = 9;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned PIX_W           = 16;
  localparam int unsigned SKIP_W          = 4;
  localparam int unsigned FRAME_CNT_W     = 8;
  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned SKIP_FRAMES_DEF = 2;

  localparam int unsigned RED_W   = 5;
  localparam int unsigned GREEN_W = 6;
  localparam int unsigned BLUE_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } capState_e;

  // RGB565 as sent by the camera: high byte first, red in the top bits
  typedef struct packed {
    logic [RED_W-1:0]   red;
    logic [GREEN_W-1:0] green;
    logic [BLUE_W-1:0]  blue;
  } rgb565_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    rgb565_t        pixel;
  } pixWrite_t;

  function automatic logic [X_W-1:0] satIncX(input logic [X_W-1:0] v);
    return (v == {X_W{1'b1}}) ? v : v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] satIncY(input logic [Y_W-1:0] v);
    return (v == {Y_W{1'b1}}) ? v : v + Y_W'(1);
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Frame buffer write port: one strobed pixel word with its coordinate.
interface ov7670_capture_if;
  import ov7670_pkg::*;

  logic             writeEn;
  logic [X_W-1:0]   outX;
  logic [Y_W-1:0]   outY;
  logic [PIX_W-1:0] pixelOut;

  modport master (output writeEn, outX, outY, pixelOut);
  modport slave  (input  writeEn, outX, outY, pixelOut);

endinterface

// File: rtl/ov7670_byte_pairer.sv
// Registers the camera bus and pairs consecutive bytes into RGB565 pixels.
module ov7670_byte_pairer
  import ov7670_pkg::*;
(
  input  logic              writeClk,
  input  logic              resetN,
  input  logic              pairEn,
  input  logic              pairClr,
  input  logic              vsync,
  input  logic              href,
  input  logic [BYTE_W-1:0] camData,
  output logic              vsQ,
  output logic              vsQQ,
  output logic              hrQ,
  output logic              hrQQ,
  output logic              bytePhase,
  output logic              pixelValid,
  output rgb565_t           pixel16
);

  logic [BYTE_W-1:0] dQ;
  logic [BYTE_W-1:0] hiByte;

  always_ff @(posedge writeClk) begin
    if (!resetN) begin
      vsQ        <= 1'b0;
      vsQQ       <= 1'b0;
      hrQ        <= 1'b0;
      hrQQ       <= 1'b0;
      dQ         <= '0;
      hiByte     <= '0;
      bytePhase  <= 1'b0;
      pixelValid <= 1'b0;
      pixel16    <= '0;
    end else begin
      vsQ        <= vsync;
      vsQQ       <= vsQ;
      hrQ        <= href;
      hrQQ       <= hrQ;
      dQ         <= camData;
      pixelValid <= 1'b0;
      // Clear wins so every line and every frame starts on a high byte
      if (pairClr) begin
        bytePhase <= 1'b0;
      end else if (pairEn && hrQ) begin
        if (!bytePhase) begin
          hiByte    <= dQ;
          bytePhase <= 1'b1;
        end else begin
          pixel16    <= {hiByte, dQ};
          pixelValid <= 1'b1;
          bytePhase  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: frame sync, settling-frame skip, pixel coordinates and frame buffer writes.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned SKIP_FRAMES = SKIP_FRAMES_DEF
) (
  input  logic                   writeClk,
  input  logic                   resetN,
  input  logic                   captureEn,
  input  logic                   vsync,
  input  logic                   href,
  input  logic [BYTE_W-1:0]      camData,
  ov7670_capture_if.master       wr,
  output logic                   frameDone,
  output logic [FRAME_CNT_W-1:0] frameCount,
  output logic                   lineErr
);

  localparam logic [X_W-1:0] H_LIM = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_ACTIVE);

  capState_e state;
  capState_e stateNext;

  logic vsQ, vsQQ, hrQ, hrQQ;
  logic bytePhase, pixelValid;
  rgb565_t pixel16;

  logic vsFall, vsRise, hrFall, capRise;
  logic capEnQ;
  logic loadSkip, decSkip, startFrame, endFrame;
  logic [SKIP_W-1:0] skipCnt;
  logic [X_W-1:0] x, xEnd;
  logic [Y_W-1:0] y;
  logic lineBad;
  logic writeEn;
  pixWrite_t wrPay;

  ov7670_byte_pairer u_pairer (
    .writeClk   (writeClk),
    .resetN     (resetN),
    .pairEn     (state == ACTIVE),
    .pairClr    ((state != ACTIVE) || hrFall),
    .vsync      (vsync),
    .href       (href),
    .camData    (camData),
    .vsQ        (vsQ),
    .vsQQ       (vsQQ),
    .hrQ        (hrQ),
    .hrQQ       (hrQQ),
    .bytePhase  (bytePhase),
    .pixelValid (pixelValid),
    .pixel16    (pixel16)
  );

  assign vsFall  = vsQQ & ~vsQ;
  assign vsRise  = ~vsQQ & vsQ;
  assign hrFall  = hrQQ & ~hrQ;
  assign capRise = captureEn & ~capEnQ;

  // The last pixel of a line lands in the same cycle as the href fall
  assign xEnd    = pixelValid ? satIncX(x) : x;
  assign lineBad = hrFall && ((xEnd != H_LIM) || bytePhase);

  always_ff @(posedge writeClk) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    loadSkip   = 1'b0;
    decSkip    = 1'b0;
    startFrame = 1'b0;
    endFrame   = 1'b0;
    case (state)
      IDLE: begin
        if (capRise) begin
          stateNext = SYNC;
          loadSkip  = 1'b1;
        end
      end
      SYNC: begin
        if (!captureEn) begin
          stateNext = IDLE;
        end else if (vsFall) begin
          if (skipCnt != '0) begin
            decSkip = 1'b1;
          end else begin
            stateNext  = ACTIVE;
            startFrame = 1'b1;
          end
        end
      end
      ACTIVE: begin
        // A started frame always runs to its vsync rise
        if (vsRise) begin
          endFrame  = 1'b1;
          stateNext = captureEn ? SYNC : IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge writeClk) begin
    if (!resetN) begin
      capEnQ     <= 1'b0;
      skipCnt    <= '0;
      x          <= '0;
      y          <= '0;
      writeEn    <= 1'b0;
      wrPay      <= '0;
      frameDone  <= 1'b0;
      frameCount <= '0;
      lineErr    <= 1'b0;
    end else begin
      capEnQ    <= captureEn;
      writeEn   <= 1'b0;
      frameDone <= 1'b0;

      if (loadSkip)     skipCnt <= SKIP_W'(SKIP_FRAMES);
      else if (decSkip) skipCnt <= skipCnt - SKIP_W'(1);

      if (startFrame) begin
        x <= '0;
        y <= '0;
      end else if (state == ACTIVE) begin
        if (hrFall) begin
          x <= '0;
          if (!vsRise) y <= satIncY(y);
        end else if (pixelValid) begin
          x <= satIncX(x);
        end
        if (pixelValid && (x < H_LIM) && (y < V_LIM)) begin
          writeEn     <= 1'b1;
          wrPay.x     <= x;
          wrPay.y     <= y;
          wrPay.pixel <= pixel16;
        end
      end

      if (capRise) lineErr <= 1'b0;
      if ((state == ACTIVE) && lineBad) lineErr <= 1'b1;

      if (endFrame) begin
        frameDone  <= 1'b1;
        frameCount <= frameCount + FRAME_CNT_W'(1);
      end
    end
  end

  assign wr.writeEn  = writeEn;
  assign wr.outX     = wrPay.x;
  assign wr.outY     = wrPay.y;
  assign wr.pixelOut = wrPay.pixel;

endmodule

// File: tb/tb_ov7670_capture.sv
// Drives random camera frames into two captures (skip 0 and skip 2) and checks every write.
module tb_ov7670_capture;

  localparam int H = 16;
  localparam int V = 6;

  logic       writeClk  = 1'b0;
  logic       resetN    = 1'b0;
  logic       captureEn = 1'b0;
  logic       vsync     = 1'b1;
  logic       href      = 1'b0;
  logic [7:0] camData   = 8'h00;

  logic       fd0, fd2, le0, le2;
  logic [7:0] fc0, fc2;

  ov7670_capture_if wr0 ();
  ov7670_capture_if wr2 ();

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0)) dut0 (
    .writeClk(writeClk), .resetN(resetN), .captureEn(captureEn), .vsync(vsync),
    .href(href), .camData(camData), .wr(wr0), .frameDone(fd0), .frameCount(fc0),
    .lineErr(le0));

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut2 (
    .writeClk(writeClk), .resetN(resetN), .captureEn(captureEn), .vsync(vsync),
    .href(href), .camData(camData), .wr(wr2), .frameDone(fd2), .frameCount(fc2),
    .lineErr(le2));

  always #5 writeClk = ~writeClk;

  int unsigned cyc = 0;
  always @(posedge writeClk) cyc <= cyc + 1;

  typedef struct {
    int          x;
    int          y;
    int          pix;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  // Reference model state per capture instance (index 0: skip 0, index 1: skip 2)
  bit armed[2];
  bit cap[2];
  bit errExp[2];
  int skipLeft[2];
  int cntExp[2];
  int fdExp[2];
  int fdSeen[2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, req);
    end
  endtask

  task automatic monWrite(input int d, input logic we, input logic [9:0] x, input logic [8:0] y,
                          input logic [15:0] p);
    exp_t e;
    int   n;
    if (we !== 1'b0) begin
      n = (d == 0) ? q0.size() : q1.size();
      chk("write_expected", d, 32'(n != 0), 32'd1);
      if (n != 0) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk("outX", d, 32'(x), e.x);
        chk("outY", d, 32'(y), e.y);
        chk("pixelOut", d, 32'(p), e.pix);
        chk("write_latency", d, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge writeClk) begin
    if (fd0 === 1'b1) fdSeen[0]++;
    if (fd2 === 1'b1) fdSeen[1]++;
    monWrite(0, wr0.writeEn, wr0.outX, wr0.outY, wr0.pixelOut);
    monWrite(1, wr2.writeEn, wr2.outX, wr2.outY, wr2.pixelOut);
  end

  task automatic step(input bit vs, input bit hr, input logic [7:0] d);
    @(posedge writeClk);
    #1;
    vsync   = vs;
    href    = hr;
    camData = d;
  endtask

  task automatic setEn(input bit v);
    if (v && !captureEn) begin
      for (int d = 0; d < 2; d++) begin
        errExp[d] = 1'b0;
        if (!cap[d]) begin
          armed[d]    = 1'b1;
          skipLeft[d] = (d == 0) ? 0 : 2;
        end
      end
    end else if (!v) begin
      for (int d = 0; d < 2; d++) if (!cap[d]) armed[d] = 1'b0;
    end
    captureEn = v;
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      armed[d]  = 1'b0;
      cap[d]    = 1'b0;
      errExp[d] = 1'b0;
      cntExp[d] = 0;
      fdExp[d]  = 0;
      fdSeen[d] = 0;
    end
  endtask

  task automatic checkReset();
    chk("rst_writeEn", 0, 32'(wr0.writeEn), 0);
    chk("rst_outX", 0, 32'(wr0.outX), 0);
    chk("rst_outY", 0, 32'(wr0.outY), 0);
    chk("rst_pixelOut", 0, 32'(wr0.pixelOut), 0);
    chk("rst_frameDone", 0, 32'(fd0), 0);
    chk("rst_frameCount", 0, 32'(fc0), 0);
    chk("rst_lineErr", 0, 32'(le0), 0);
    chk("rst_writeEn", 1, 32'(wr2.writeEn), 0);
    chk("rst_outX", 1, 32'(wr2.outX), 0);
    chk("rst_outY", 1, 32'(wr2.outY), 0);
    chk("rst_pixelOut", 1, 32'(wr2.pixelOut), 0);
    chk("rst_frameDone", 1, 32'(fd2), 0);
    chk("rst_frameCount", 1, 32'(fc2), 0);
    chk("rst_lineErr", 1, 32'(le2), 0);
  endtask

  task automatic checkFrame();
    chk("missing_writes", 0, 32'(q0.size()), 0);
    chk("missing_writes", 1, 32'(q1.size()), 0);
    chk("frameDone_pulses", 0, 32'(fdSeen[0]), 32'(fdExp[0]));
    chk("frameDone_pulses", 1, 32'(fdSeen[1]), 32'(fdExp[1]));
    chk("frameCount", 0, 32'(fc0), 32'(cntExp[0] % 256));
    chk("frameCount", 1, 32'(fc2), 32'(cntExp[1] % 256));
    chk("lineErr", 0, 32'(le0), 32'(errExp[0]));
    chk("lineErr", 1, 32'(le2), 32'(errExp[1]));
  endtask

  // One camera frame; negative line indices disable the corresponding event
  task automatic sendFrame(input int nLines, input int badLine, input int badBytes,
                           input int dropLine, input bit tight, input int resetLine,
                           input bit fixFirst);
    logic [7:0] hi;
    logic [7:0] b;
    int         nb;
    exp_t       e;
    hi = 8'h00;
    repeat (6) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      cap[d] = 1'b0;
      if (armed[d] && captureEn) begin
        if (skipLeft[d] > 0) skipLeft[d]--;
        else cap[d] = 1'b1;
      end
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
    for (int y = 0; y < nLines; y++) begin
      if (y == dropLine) setEn(1'b0);
      nb = (y == badLine) ? badBytes : 2 * H;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        if (fixFirst && y == 0 && i == 0) b = 8'hF8;
        if (fixFirst && y == 0 && i == 1) b = 8'h1F;
        step(1'b0, 1'b1, b);
        if (y == resetLine && i == 7) begin
          resetN    = 1'b0;
          captureEn = 1'b0;
        end
        if (i % 2 == 0) begin
          hi = b;
        end else begin
          e.x   = i / 2;
          e.y   = y;
          e.pix = 32'({hi, b});
          e.cyc = cyc + 3;
          if (cap[0] && y < V && i / 2 < H) q0.push_back(e);
          if (cap[1] && y < V && i / 2 < H) q1.push_back(e);
        end
        if (y == resetLine && i == 8) begin
          resetN = 1'b1;
          modelReset();
          @(negedge writeClk);
          checkReset();
        end
      end
      for (int d = 0; d < 2; d++)
        if (cap[d] && ((nb % 2 != 0) || (nb / 2 != H))) errExp[d] = 1'b1;
      if (tight && y == nLines - 1) step(1'b1, 1'b0, 8'h00);
      else repeat (2 + $urandom_range(0, 3)) step(1'b0, 1'b0, 8'h00);
    end
    if (!tight) step(1'b1, 1'b0, 8'h00);
    for (int d = 0; d < 2; d++) begin
      if (cap[d]) begin
        cntExp[d]++;
        fdExp[d]++;
        armed[d] = captureEn;
        cap[d]   = 1'b0;
      end
    end
    repeat (6) step(1'b1, 1'b0, 8'h00);
    checkFrame();
  endtask

  initial begin
    modelReset();
    repeat (3) step(1'b1, 1'b0, 8'h00);
    @(negedge writeClk);
    checkReset();
    step(1'b1, 1'b0, 8'h00);
    resetN = 1'b1;
    repeat (3) step(1'b1, 1'b0, 8'h00);

    setEn(1'b1);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    sendFrame(V, -1, 0, -1, 1'b0, -1, 1'b0);
    sendFrame(V, -1, 0, -1, 1'b1, -1, 1'b0);
    sendFrame(V + 1, -1, 0, -1, 1'b0, -1, 1'b0);
    sendFrame(V, 2, 2 * H + 2, -1, 1'b0, -1, 1'b0);

    setEn(1'b0);
    repeat (3) step(1'b1, 1'b0, 8'h00);
    setEn(1'b1);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    sendFrame(V, 1, 2 * H - 1, -1, 1'b0, -1, 1'b0);
    sendFrame(V, -1, 0, 3, 1'b0, -1, 1'b0);
    sendFrame(V, -1, 0, -1, 1'b0, -1, 1'b0);

    setEn(1'b1);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    sendFrame(V, 4, 2 * H + 1, -1, 1'b0, -1, 1'b1);
    sendFrame(V, -1, 0, -1, 1'b0, 3, 1'b0);
    sendFrame(V, -1, 0, -1, 1'b0, -1, 1'b0);

    setEn(1'b1);
    repeat (4) step(1'b1, 1'b0, 8'h00);
    sendFrame(V, -1, 0, -1, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
Write-side producer for the camera frame buffer. Samples the OV7670 parallel bus (vsync, href, 8-bit data), pairs bytes into RGB565 pixels, and generates the pixel coordinate, write strobe and 16-bit pixel word that the frame buffer's write port consumes. It also synchronises to frame boundaries, discards settling frames after enable, and reports frame completion and line-length errors.

Parameters:
H_ACTIVE, 640, pixels per line; writes are generated only for x < H_ACTIVE.
V_ACTIVE, 480, lines per frame; writes are generated only for y < V_ACTIVE.
SKIP_FRAMES, 2, whole frames discarded after each captureEn rise (range 0-15).

Ports:
writeClk  in  1  camera pixel clock; all logic on its rising edge.
resetN  in  1  synchronous, active-low reset.
captureEn  in  1  level; capture runs while high (driven by camera-config-done).
vsync  in  1  camera VSYNC, high between frames.
href  in  1  camera HREF, high during active line bytes.
camData  in  8  camera data byte.
outX  out  10  x of the pixel on pixelOut.
outY  out  9  y of the pixel on pixelOut.
writeEn  out  1  one-cycle strobe; pixelOut/outX/outY valid while high.
pixelOut  out  16  RRRRR_GGGGGG_BBBBB.
frameDone  out  1  one-cycle pulse at end of each captured frame.
frameCount  out  8  captured frames since reset, wraps 255->0.
lineErr  out  1  sticky; set on a malformed line, cleared only by reset or captureEn rise.

Behaviour:
- Reset (resetN low at a writeClk edge): state IDLE; outX=0, outY=0, writeEn=0, pixelOut=0, frameDone=0, frameCount=0, lineErr=0; internal x, y, bytePhase, skip counter cleared. Reset mid-frame aborts with no further writes.
- Input stage: vsync, href, camData registered once (vsQ, hrQ, dQ); a second vsync/href register gives edge detection. All decisions use registered values.
- States: IDLE, SYNC, ACTIVE.
  IDLE: captureEn rise -> SYNC, skip counter = SKIP_FRAMES, lineErr cleared.
  SYNC: on vsQ falling edge: if skip counter > 0, decrement and stay; else -> ACTIVE with x=0, y=0, bytePhase=0. If captureEn is low -> IDLE.
  ACTIVE: byte pairing while hrQ=1: phase 0 latches dQ as high byte; phase 1 forms {high,dQ}. On the cycle after phase 1, writeEn=1 with pixelOut={high,low}, outX=x, outY=y, but only if x<H_ACTIVE and y<V_ACTIVE. x increments per pixel, saturating at 1023.
- Latency: a low byte present on camData at edge k gives writeEn high on the cycle starting at edge k+2. Throughput: one pixel per 2 clocks.
- hrQ falling edge: if x != H_ACTIVE or bytePhase=1, set lineErr. Then x=0, bytePhase=0, y increments, saturating at 511. Lines with y >= V_ACTIVE produce no writes.
- vsQ rising edge in ACTIVE: frameDone=1 for one cycle, frameCount+1. Next state is SYNC if captureEn=1, else IDLE. A frame therefore always completes once started, even if captureEn drops mid-frame.
- Simultaneous hrQ fall and vsQ rise: the line check and lineErr update are applied, y is not incremented, and frame end is taken.
- In IDLE/SYNC, writeEn and frameDone stay 0. outX, outY and pixelOut hold their last values.
- Outputs are registered; there are no combinational paths from inputs.

Decomposition:
- Shared package ov7670_pkg: state enum (IDLE/SYNC/ACTIVE), H_ACTIVE/V_ACTIVE defaults, coordinate widths (10/9), RGB565 field positions. The frame buffer imports the same widths.
- One natural sub-module: ov7670_byte_pairer. It contains the input register stage, bytePhase toggle and high-byte latch, and outputs pixelValid/pixel16. The FSM and counters stay in the top.

Test Plan:
1. Reset then captureEn=1, SKIP_FRAMES=0; one frame of 480 lines x 1280 bytes, pixel n of line y = {y[7:0], n[7:0]} -> exactly 307200 writeEn pulses, each pixelOut matches with outX=n, outY=y, one frameDone, frameCount=1, lineErr=0.
2. SKIP_FRAMES=2, three frames sent -> zero writes during frames 0 and 1; frame 2 fully written; frameCount=1.
3. Line of 1282 bytes (641 pixels) -> writes only for x 0..639, lineErr=1 after href falls. A line of 1279 bytes also sets lineErr.
4. captureEn dropped at line 100 -> the frame still completes through line 479 with frameDone; the state goes to IDLE and the next frame produces no writes.
5. Bytes 0xF8,0x1F at line 0 start -> writeEn exactly 2 clocks after 0x1F is on camData, pixelOut=0xF81F, outX=0, outY=0.
6. resetN low mid-line (line 37) -> writeEn=0 next cycle, all outputs at reset values, and no writes until a new captureEn rise plus vsync fall.
